// File: rtl/pixel_serializer.sv
// rtl/pixel_serializer.sv - batch-to-pixel serializer with raster tracking
//
// Purpose:
//   Captures one batch of NUM_ENGINES RGB values for consecutive x positions.
//   Streams the batch out one pixel per cycle on a valid/ready interface.
//   Tracks the raster (x, y) position and flags start-of-frame and end-of-line.
//   The final partial batch of each line is truncated to the pixels left on
//   that line.
//
// Optional feature:
//   PIXEL_SERIALIZER_PREFETCH_EN adds a shadow buffer. The next batch is then
//   accepted while the current one streams, and it is promoted to active
//   without a bubble. When the macro is undefined the block is single-buffered.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   batch_valid  rgb_in holds a complete batch
//   batch_ready  a batch can be captured this cycle
//   rgb_in       lane i = pixel at x_base + i
//   pix_data     colour of the presented pixel
//   pix_valid    pix_data / pix_sof / pix_eol / pix_x / pix_y are valid
//   pix_ready    downstream accepts the presented pixel
//   pix_sof      presented pixel is (0, 0)
//   pix_eol      presented pixel is the last of its line
//   pix_x/pix_y  raster position of the presented pixel
module pixel_serializer #(
  parameter int RGB_SIZE    = 24,
  parameter int NUM_ENGINES = 30,
  parameter int X_SIZE      = 640,
  parameter int Y_SIZE      = 480,
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                batch_valid,
  output logic                batch_ready,
  input  logic [RGB_SIZE-1:0] rgb_in [NUM_ENGINES-1:0],
  output logic [RGB_SIZE-1:0] pix_data,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                pix_sof,
  output logic                pix_eol,
  output logic [X_WIDTH-1:0]  pix_x,
  output logic [Y_WIDTH-1:0]  pix_y
);

  localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(X_SIZE - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(Y_SIZE - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  // Index of the last lane kept for a batch starting at base.
  function automatic logic [IDX_W-1:0] last_lane(input logic [X_WIDTH-1:0] base);
    int rem;
    rem = X_SIZE - int'(base);
    if (rem >= NUM_ENGINES) return IDX_W'(NUM_ENGINES - 1);
    return IDX_W'(rem - 1);
  endfunction

  // x position following a batch; wraps to 0 when the batch closes the line.
  function automatic logic [X_WIDTH-1:0] batch_end(input logic [X_WIDTH-1:0] base,
                                                   input logic [IDX_W-1:0]   last);
    int e;
    e = int'(base) + int'(last) + 1;
    return (e >= X_SIZE) ? '0 : X_WIDTH'(e);
  endfunction

  state_t                state_q, state_d;
  logic [RGB_SIZE-1:0]   act_q [NUM_ENGINES-1:0];
  logic [RGB_SIZE-1:0]   act_d [NUM_ENGINES-1:0];
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      last_q, last_d;
  // Start x of the next batch to be loaded. Every batch begins where the
  // previous one ended, including a prefetched batch.
  logic [X_WIDTH-1:0]    x_end_q, x_end_d;
  logic [X_WIDTH-1:0]    pix_x_q, pix_x_d;
  logic [Y_WIDTH-1:0]    pix_y_q, pix_y_d;
  logic [RGB_SIZE-1:0]   pix_data_q, pix_data_d;
  logic                  pix_valid_q, pix_valid_d;
  logic                  pix_sof_q, pix_sof_d;
  logic                  pix_eol_q, pix_eol_d;
  logic                  batch_ready_q, batch_ready_d;

`ifdef PIXEL_SERIALIZER_PREFETCH_EN
  logic [RGB_SIZE-1:0]   sh_q [NUM_ENGINES-1:0];
  logic [RGB_SIZE-1:0]   sh_d [NUM_ENGINES-1:0];
  logic                  sh_full_q, sh_full_d;
  logic [IDX_W-1:0]      sh_last_q, sh_last_d;
  logic                  load_sh;
`endif

  logic                  accept, hs, last_hs, load_in;
  logic [IDX_W-1:0]      new_last;

  always_comb begin
    state_d       = state_q;
    act_d         = act_q;
    idx_d         = idx_q;
    last_d        = last_q;
    x_end_d       = x_end_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_data_d    = pix_data_q;
    load_in       = 1'b0;
`ifdef PIXEL_SERIALIZER_PREFETCH_EN
    sh_d          = sh_q;
    sh_full_d     = sh_full_q;
    sh_last_d     = sh_last_q;
    load_sh       = 1'b0;
`endif

    accept   = batch_valid && batch_ready_q;
    hs       = pix_valid_q && pix_ready;
    last_hs  = hs && (idx_q == last_q);
    new_last = last_lane(x_end_q);

    if (hs) begin
      idx_d = idx_q + 1'b1;
      if (pix_x_q == X_LAST) begin
        pix_x_d = '0;
        pix_y_d = (pix_y_q == Y_LAST) ? '0 : pix_y_q + 1'b1;
      end else begin
        pix_x_d = pix_x_q + 1'b1;
      end
    end

`ifdef PIXEL_SERIALIZER_PREFETCH_EN
    if (state_q == IDLE) begin
      load_in = accept;
    end else if (last_hs) begin
      // Shadow takes priority; a batch offered in this cycle can only be
      // accepted when the shadow is empty, so it goes straight to active.
      if (sh_full_q)   load_sh = 1'b1;
      else if (accept) load_in = 1'b1;
      else             state_d = IDLE;
    end else if (accept) begin
      sh_d      = rgb_in;
      sh_full_d = 1'b1;
      sh_last_d = new_last;
    end

    if (load_sh) begin
      act_d     = sh_q;
      idx_d     = '0;
      last_d    = sh_last_q;
      x_end_d   = batch_end(x_end_q, sh_last_q);
      sh_full_d = 1'b0;
      state_d   = STREAM;
    end
`else
    if (state_q == IDLE) begin
      load_in = accept;
    end else if (last_hs) begin
      state_d = IDLE;
    end
`endif

    if (load_in) begin
      act_d   = rgb_in;
      idx_d   = '0;
      last_d  = new_last;
      x_end_d = batch_end(x_end_q, new_last);
      state_d = STREAM;
    end

    pix_valid_d = (state_d == STREAM);
`ifdef PIXEL_SERIALIZER_PREFETCH_EN
    batch_ready_d = !sh_full_d;
`else
    batch_ready_d = (state_d == IDLE);
`endif
    // Outputs are registered from the next-state values, so the presented
    // pixel and its flags change together and hold under backpressure.
    if (pix_valid_d) pix_data_d = act_d[idx_d];
    pix_sof_d = pix_valid_d && (pix_x_d == '0) && (pix_y_d == '0);
    pix_eol_d = pix_valid_d && (pix_x_d == X_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      act_q         <= '{default: '0};
      idx_q         <= '0;
      last_q        <= '0;
      x_end_q       <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_data_q    <= '0;
      pix_valid_q   <= 1'b0;
      pix_sof_q     <= 1'b0;
      pix_eol_q     <= 1'b0;
      batch_ready_q <= 1'b1;
`ifdef PIXEL_SERIALIZER_PREFETCH_EN
      sh_q          <= '{default: '0};
      sh_full_q     <= 1'b0;
      sh_last_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      act_q         <= act_d;
      idx_q         <= idx_d;
      last_q        <= last_d;
      x_end_q       <= x_end_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_data_q    <= pix_data_d;
      pix_valid_q   <= pix_valid_d;
      pix_sof_q     <= pix_sof_d;
      pix_eol_q     <= pix_eol_d;
      batch_ready_q <= batch_ready_d;
`ifdef PIXEL_SERIALIZER_PREFETCH_EN
      sh_q          <= sh_d;
      sh_full_q     <= sh_full_d;
      sh_last_q     <= sh_last_d;
`endif
    end
  end

  assign batch_ready = batch_ready_q;
  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign pix_sof     = pix_sof_q;
  assign pix_eol     = pix_eol_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;

endmodule

// File: doc/pixel_serializer.md
Name: pixel_serializer

Overview:
- Sits downstream of the iteration-to-colour LUT. Consumes one batch of NUM_ENGINES parallel RGB values, one per engine, and covering consecutive x positions.
- Streams the batch out one pixel per cycle on a valid/ready pixel interface toward the video/frame-buffer side.
- Tracks the raster position (x, y) and flags start-of-frame and end-of-line.
- Truncates the final partial batch of each line.

Parameters:
- RGB_SIZE, 24, width of one pixel colour.
- NUM_ENGINES, 30, number of parallel RGB lanes per batch.
- X_SIZE, 640, pixels per line.
- Y_SIZE, 480, lines per frame.
- X_WIDTH, 10, width of x counter; must satisfy 2**X_WIDTH >= X_SIZE.
- Y_WIDTH, 9, width of y counter; must satisfy 2**Y_WIDTH >= Y_SIZE.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- batch_valid  in  1  rgb_in holds a complete batch.
- batch_ready  out  1  block can capture a batch this cycle.
- rgb_in  in  RGB_SIZE x NUM_ENGINES (unpacked array [NUM_ENGINES-1:0])  lane i = pixel at x_base+i.
- pix_data  out  RGB_SIZE  current pixel colour.
- pix_valid  out  1  pix_data/pix_sof/pix_eol valid.
- pix_ready  in  1  downstream accepts pixel.
- pix_sof  out  1  current pixel is (0,0).
- pix_eol  out  1  current pixel is x == X_SIZE-1.
- pix_x  out  X_WIDTH  x of current pixel.
- pix_y  out  Y_WIDTH  y of current pixel.

Behaviour:
- Reset (async assert, sync release): pix_valid=0, pix_data=0, pix_sof=0, pix_eol=0, pix_x=0, pix_y=0, batch_ready=1, state=IDLE, buffers empty.
- All outputs are registered.
- Batch accept happens on batch_valid && batch_ready:
  - Capture all lanes into the active buffer.
  - Set lane index idx=0.
  - Set count = min(NUM_ENGINES, X_SIZE - x_base).
  - Lanes >= count are discarded.
- States:
  - IDLE: batch_ready=1, pix_valid=0. On accept, go to STREAM next cycle.
  - STREAM: pix_valid=1, batch_ready=0 (see optional feature), pix_data=buf[idx].
- Latency: first pixel is valid the cycle after accept.
- Pixel handshake fires on pix_valid && pix_ready. On each handshake:
  - idx++ and x++.
  - If x == X_SIZE-1, x goes to 0 and y++.
  - If y == Y_SIZE-1 at end of line, y wraps to 0 (next frame).
- Last lane: on handshake with idx == count-1, go to IDLE, with batch_ready=1 next cycle.
- Throughput without the optional feature: count pixels per count+1 cycles.
- Backpressure: while pix_valid && !pix_ready, pix_data, pix_sof, pix_eol, pix_x and pix_y hold stable. No pixel is dropped or duplicated.
- Flag generation: pix_sof = (x==0 && y==0); pix_eol = (x==X_SIZE-1). Both are evaluated for the presented pixel.
- Line boundary: a batch never spans two lines. After eol, the next batch starts at x=0.
- batch_valid while batch_ready=0 is ignored; the upstream holds rgb_in.
- Reset mid-stream: buffers are flushed and x and y return to 0. The next accepted batch starts a frame with pix_sof=1.

Optional Feature:
- Macro: PIXEL_SERIALIZER_PREFETCH_EN.
- When defined, a second (shadow) buffer is added:
  - batch_ready=1 whenever the shadow buffer is empty, including during STREAM.
  - On the last-lane handshake with the shadow full, the shadow moves to active with no bubble (pix_valid stays 1). Sustained throughput is 1 pixel/cycle.
  - An accept in the same cycle as the last-lane handshake is legal. If the shadow was empty, the new batch goes directly to active.
  - Count computation for a prefetched batch uses the x_base it will start at.
- When undefined, the block is single-buffered as described in Behaviour.

Test Plan:
- Params NUM_ENGINES=4, X_SIZE=6, Y_SIZE=2, pix_ready=1. Send batch {A0..A3}, then {B0..B3} -> output A0,A1,A2,A3,B0,B1. B2 and B3 are discarded. pix_sof=1 on A0 only; pix_eol=1 on B1; pix_x runs 0..5.
- Full frame, 3 lines x 2 batches (Y_SIZE=2, so the third line is the next frame) -> pix_y goes 0,0->1 after first eol, wraps to 0 after second eol. pix_sof is reasserted on the first pixel of the 5th batch.
- Toggle pix_ready 1,0,0,1 during batch {10,20,30,40} -> pix_data holds 20 for 3 cycles. Output sequence is exactly 10,20,30,40 with no duplicates.
- Assert rst asynchronously mid-batch after 2 pixels -> pix_valid drops to 0 immediately and batch_ready=1 after release. The next batch outputs with pix_x=0 and pix_sof=1.
- Without prefetch, back-to-back batches with batch_valid held high -> one cycle with pix_valid=0 between batches. With PIXEL_SERIALIZER_PREFETCH_EN -> zero gap cycles, and batch_ready=1 during STREAM with the shadow empty.
- batch_valid asserted while in STREAM (no prefetch) -> batch_ready=0 and no capture. rgb_in changes while unaccepted do not affect output.
